// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
//
// Counts spikes over fixed windows of WINDOW enabled clock cycles and presents
// the (saturated) count of the most recently completed window on a
// valid/ready output. A result that is replaced before being consumed sets a
// sticky overrun flag.
//
// Parameters
//   WINDOW      enabled cycles per counting window (2..65535)
//   OUT_W       width of the rate result (4..16)
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous reset, active high
//   en          count enable; window position and count advance only when high
//   spike       one spike counted per enabled cycle in which it is high
//   rate        saturated spike count of the last completed window
//   rate_valid  rate holds an unconsumed result
//   rate_ready  consumer accepts rate when rate_valid is also high
//   overrun     sticky: a result was overwritten before it was consumed
//
// All outputs are registered; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module spike_rate_decoder #(
    parameter int WINDOW = 256,
    parameter int OUT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             spike,
    output logic [OUT_W-1:0] rate,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WINDOW - 1);
    localparam logic [OUT_W-1:0] ACC_MAX  = {OUT_W{1'b1}};

    logic [CNT_W-1:0] win_cnt;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] acc_next;
    logic             last_cycle;
    logic             xfer;

    // Accumulator value including this cycle's spike; holds at full scale.
    always_comb begin
        acc_next = acc;
        if (spike && (acc != ACC_MAX)) begin
            acc_next = acc + OUT_W'(1);
        end
    end

    assign last_cycle = en && (win_cnt == LAST_POS);
    assign xfer       = rate_valid && rate_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt    <= '0;
            acc        <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (en) begin
                if (last_cycle) begin
                    win_cnt <= '0;
                    acc     <= '0;
                end else begin
                    win_cnt <= win_cnt + CNT_W'(1);
                    acc     <= acc_next;
                end
            end

            // A capture always wins over a transfer: the new result stays
            // valid. Only a capture onto an unconsumed result counts as an
            // overrun; a capture coinciding with a transfer is a clean handoff.
            if (last_cycle) begin
                rate       <= acc_next;
                rate_valid <= 1'b1;
                if (rate_valid && !rate_ready) begin
                    overrun <= 1'b1;
                end
            end else if (xfer) begin
                rate_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;

    localparam int W   = 16;
    localparam int OW  = 8;
    localparam int W2  = 512;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, spike, rate_ready;
    logic [OW-1:0] rate;
    logic          rate_valid, overrun;

    logic          en2, spike2, ready2;
    logic [OW-1:0] rate2;
    logic          valid2, ovr2;

    spike_rate_decoder #(.WINDOW(W), .OUT_W(OW)) dut (
        .clk(clk), .rst(rst), .en(en), .spike(spike),
        .rate(rate), .rate_valid(rate_valid), .rate_ready(rate_ready),
        .overrun(overrun)
    );

    spike_rate_decoder #(.WINDOW(W2), .OUT_W(OW)) dut_sat (
        .clk(clk), .rst(rst), .en(en2), .spike(spike2),
        .rate(rate2), .rate_valid(valid2), .rate_ready(ready2),
        .overrun(ovr2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: position inside the window and spike count as plain
    // integers; saturation applied only when the window result is reported.
    int  m_pos   = 0;
    int  m_cnt   = 0;
    int  m_rate  = 0;
    bit  m_valid = 0;
    bit  m_ovr   = 0;

    function automatic void model_step(input bit r, input bit e, input bit s, input bit rd);
        bit cap;
        if (r) begin
            m_pos = 0; m_cnt = 0; m_rate = 0; m_valid = 0; m_ovr = 0;
            return;
        end
        cap = 0;
        if (e) begin
            if (s) m_cnt++;
            if (m_pos == W - 1) begin
                cap = 1;
                if (m_valid && !rd) m_ovr = 1;
                m_rate  = (m_cnt > (1 << OW) - 1) ? (1 << OW) - 1 : m_cnt;
                m_valid = 1;
                m_cnt   = 0;
                m_pos   = 0;
            end else begin
                m_pos++;
            end
        end
        if (!cap && m_valid && rd) m_valid = 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, clock, advance the model, compare against it.
    task automatic cyc(input bit r, input bit e, input bit s, input bit rd);
        rst = r; en = e; spike = s; rate_ready = rd;
        @(posedge clk);
        #1;
        model_step(r, e, s, rd);
        check("model_rate",    32'(rate),       32'(m_rate));
        check("model_valid",   32'(rate_valid), 32'(m_valid));
        check("model_overrun", 32'(overrun),    32'(m_ovr));
    endtask

    typedef struct {
        int k;          // spikes on the first k cycles of each window
        bit ready;
        int windows;
        int exp_rate;
        bit exp_valid;
        bit exp_ovr;
    } vec_t;

    vec_t tbl[5];

    initial begin
        rst = 1; en = 0; spike = 0; rate_ready = 0;
        en2 = 0; spike2 = 0; ready2 = 0;

        tbl[0] = '{k: 16, ready: 0, windows: 1, exp_rate: 16, exp_valid: 1, exp_ovr: 0};
        tbl[1] = '{k: 0,  ready: 0, windows: 1, exp_rate: 0,  exp_valid: 1, exp_ovr: 0};
        tbl[2] = '{k: 3,  ready: 0, windows: 2, exp_rate: 3,  exp_valid: 1, exp_ovr: 1};
        tbl[3] = '{k: 7,  ready: 1, windows: 1, exp_rate: 7,  exp_valid: 1, exp_ovr: 0};
        tbl[4] = '{k: 1,  ready: 1, windows: 2, exp_rate: 1,  exp_valid: 1, exp_ovr: 0};

        // Reset state
        cyc(1, 1, 1, 1);
        check("reset_rate",    32'(rate),       0);
        check("reset_valid",   32'(rate_valid), 0);
        check("reset_overrun", 32'(overrun),    0);

        // Table-driven windows
        foreach (tbl[t]) begin
            cyc(1, 0, 0, 0);
            for (int w = 0; w < tbl[t].windows; w++)
                for (int c = 0; c < W; c++)
                    cyc(0, 1, c < tbl[t].k, tbl[t].ready);
            check($sformatf("tbl%0d_rate", t),    32'(rate),       32'(tbl[t].exp_rate));
            check($sformatf("tbl%0d_valid", t),   32'(rate_valid), 32'(tbl[t].exp_valid));
            check($sformatf("tbl%0d_overrun", t), 32'(overrun),    32'(tbl[t].exp_ovr));
        end

        // Continuous spikes, always ready: one-cycle valid pulse every window
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 4 * W; i++) begin
            cyc(0, 1, 1, 1);
            check("full_valid", 32'(rate_valid), (i % W == 0) ? 1 : 0);
            if (i % W == 0) check("full_rate", 32'(rate), W);
        end
        check("full_overrun", 32'(overrun), 0);

        // Alternate spikes: first valid after the 16th enabled edge
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 2 * W; i++) begin
            cyc(0, 1, (i % 2) == 0, 1);
            if (i == W - 2) check("alt_not_yet", 32'(rate_valid), 0);
            if (i == W - 1) begin
                check("alt_first_valid", 32'(rate_valid), 1);
                check("alt_rate", 32'(rate), 8);
            end
        end

        // Two unconsumed windows (3 then 5 spikes), then a single ready pulse
        cyc(1, 0, 0, 0);
        for (int c = 0; c < W; c++) cyc(0, 1, c < 3, 0);
        for (int c = 0; c < W; c++) cyc(0, 1, c < 5, 0);
        check("ovr_rate",    32'(rate),       5);
        check("ovr_valid",   32'(rate_valid), 1);
        check("ovr_overrun", 32'(overrun),    1);
        cyc(0, 0, 0, 1);
        check("ovr_cleared_valid", 32'(rate_valid), 0);
        check("ovr_sticky",        32'(overrun),    1);
        check("ovr_rate_retained", 32'(rate),       5);

        // en low for 20 cycles mid-window delays the capture by 20 cycles
        cyc(1, 0, 0, 0);
        for (int c = 0; c < 8; c++)  cyc(0, 1, 1, 1);
        for (int c = 0; c < 20; c++) cyc(0, 0, 1, 1);
        for (int c = 0; c < 7; c++)  cyc(0, 1, 1, 1);
        check("gap_not_yet", 32'(rate_valid), 0);
        cyc(0, 1, 1, 1);
        check("gap_valid", 32'(rate_valid), 1);
        check("gap_rate",  32'(rate),       W);

        // Reset mid-window with a pending, overrun result
        cyc(1, 0, 0, 0);
        for (int c = 0; c < 2 * W; c++) cyc(0, 1, 1, 0);
        for (int c = 0; c < 10; c++)    cyc(0, 1, c < 6, 0);
        cyc(1, 1, 1, 1);
        check("rst_mid_rate",    32'(rate),       0);
        check("rst_mid_valid",   32'(rate_valid), 0);
        check("rst_mid_overrun", 32'(overrun),    0);
        for (int c = 0; c < W; c++) cyc(0, 1, c < 4, 0);
        check("rst_mid_next_rate",  32'(rate),       4);
        check("rst_mid_next_valid", 32'(rate_valid), 1);
        check("rst_mid_next_ovr",   32'(overrun),    0);

        // Saturation on the long-window instance
        cyc(1, 0, 0, 0);
        en2 = 1; spike2 = 1; ready2 = 1;
        for (int i = 1; i <= 2 * W2; i++) begin
            cyc(0, 0, 0, 0);
            if (i % W2 == 0) begin
                check("sat_valid", 32'(valid2), 1);
                check("sat_rate",  32'(rate2),  255);
            end else begin
                check("sat_idle_valid", 32'(valid2), 0);
            end
        end
        check("sat_overrun", 32'(ovr2), 0);
        en2 = 0; spike2 = 0; ready2 = 0;

        // Randomized traffic against the model
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) < 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
